rca_wide_seq: RTL
=================

Name: rca_wide_seq

Overview:
- Sequencer that builds a wide W = N*SLICES-bit signed/unsigned adder by time-multiplexing one N-bit rca_nbit slice over SLICES cycles.
- Latches the wide operands, feeds one slice per cycle with the carry registered between slices, and presents sum, carry-out and signed overflow with a start/busy/done handshake.
- Keeps the combinational critical path to one N-bit ripple. Sits between a requester (CPU/test sequencer) and the existing rca_nbit datapath.

Parameters:
- N, 6, slice width; the width of the shared rca_nbit.
- SLICES, 4, number of slices per operation; must be >= 2.
- W (localparam), N*SLICES, operand/result width; not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when the block is not busy
- a  in  W  operand A; sampled on the accepted start edge only
- b  in  W  operand B; sampled on the accepted start edge only
- cin  in  1  carry into slice 0; sampled on the accepted start edge only
- busy  out  1  high while slices are being processed
- done  out  1  one-cycle pulse when the result becomes valid
- sum  out  W  result register; held until the next done
- cout  out  1  carry out of the top slice; held with sum
- ovf  out  1  signed overflow of the W-bit add; held with sum

Behaviour:
- Reset: state=IDLE, idx=0, carry=0, busy=0, done=0, sum=0, cout=0, ovf=0. Working registers are also cleared.
- States: IDLE, RUN, DONE.
  - IDLE: if start=1, latch a/b into opA/opB, carry<=cin, idx<=0, go to RUN.
  - RUN: the rca_nbit inputs are opA[idx*N +: N], opB[idx*N +: N] and carry. Each edge: work[idx*N +: N]<=slice sum, carry<=slice cout, idx<=idx+1. When idx==SLICES-1, go to DONE instead of incrementing.
  - DONE: done=1 for exactly this cycle. sum<=work, cout<=carry and ovf are registered on the edge entering DONE, so they are valid while done=1.
  - DONE exit: if start=1, latch new operands and go to RUN (back-to-back operation); otherwise go to IDLE.
- Overflow: ovf = (opA[W-1]==opB[W-1]) && (final sum[W-1]!=opA[W-1]). This is independent of cin semantics beyond its effect on the sum.
- busy=1 exactly in RUN. start while busy is ignored and not queued. a/b/cin may change freely after the accepted start edge.
- Latency: start accepted at edge k gives RUN on cycles k+1..k+SLICES and done=1 in cycle k+SLICES+1. With defaults, done is high 5 cycles after the start cycle.
- Throughput: one result every SLICES+1 cycles when start is held high.
- Outputs sum/cout/ovf change only on the edge into DONE. They remain stable through IDLE and the following RUN.
- Wrap-around: arithmetic is modulo 2^W. cout reports the unsigned carry and ovf the signed overflow; both may be 1 at the same time.
- Reset mid-operation: rst at any edge overrides everything and returns to the reset state. No done pulse, sum is cleared, and the aborted operation is lost.
- Reset and start in the same cycle: reset wins and start is dropped.

Decomposition:
- Package rca_pkg holds:
  - the typedef enum logic [1:0] {IDLE, RUN, DONE} rca_seq_state_t;
  - a constant for the default slice width (6).
- Sub-module: the existing rca_nbit (ports A, B, cin, sum, cout), instantiated once with its width set to N. Its combinational timing must close within one clk period.
- idx counter width: $clog2(SLICES).

Test Plan (N=6, SLICES=4, W=24):
- start with a=24'h00003F, b=24'h000001, cin=0 -> carry crosses slice 0->1; sum=24'h000040, cout=0, ovf=0; done exactly 5 cycles after start, busy high 4 cycles.
- a=24'hFFFFFF, b=24'h000001, cin=0 -> full ripple through all slices; sum=24'h000000, cout=1, ovf=0.
- a=24'h7FFFFF, b=24'h000000, cin=1 -> sum=24'h800000, cout=0, ovf=1. Then a=b=24'h800000, cin=0 -> sum=0, cout=1, ovf=1.
- Hold start=1 with op1 (1+2) then op2 (24'hFFFFF0+16): done pulses are 5 cycles apart with sums 3 then 0 (cout=1). A start pulse injected mid-RUN is ignored and produces no extra done.
- Assert rst during the 2nd RUN cycle of a=24'h123456, b=24'h111111 -> next cycle busy=0, sum=0, no done pulse. A subsequent start of the same operands yields sum=24'h234567.
- Random regression: 10k random a/b/cin against the model {cout,sum}=a+b+cin with signed-overflow check, including back-to-back starts.

Source files
------------

// File: rtl/rca_pkg.sv
// Shared definitions for the time-multiplexed wide adder.
//   rca_seq_state_t : sequencer states (IDLE, RUN, DONE)
//   RCA_DEFAULT_N   : default width of the shared ripple-carry slice
package rca_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rca_seq_state_t;

  localparam int RCA_DEFAULT_N = 6;

endpackage

// File: rtl/rca_nbit.sv
// Purely combinational N-bit ripple-carry adder slice.
//   A, B : N-bit addends
//   cin  : carry in
//   sum  : N-bit sum
//   cout : carry out of the top bit
module rca_nbit
  import rca_pkg::*;
#(
  parameter int N = RCA_DEFAULT_N
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry_chain;

  assign carry_chain[0] = cin;

  for (genvar gi = 0; gi < N; gi++) begin : g_fa
    assign sum[gi]           = A[gi] ^ B[gi] ^ carry_chain[gi];
    assign carry_chain[gi+1] = (A[gi] & B[gi]) | (carry_chain[gi] & (A[gi] ^ B[gi]));
  end

  assign cout = carry_chain[N];

endmodule

// File: rtl/rca_wide_seq.sv
// Wide (N*SLICES-bit) adder built by running one N-bit rca_nbit slice
// over SLICES consecutive cycles, with the inter-slice carry registered.
//   clk, rst : clock, synchronous active-high reset
//   start    : request, accepted only in IDLE or DONE
//   a, b     : W-bit operands, cin : carry into slice 0 (latched on accept)
//   busy     : high while slices are processed (RUN)
//   done     : one-cycle pulse when sum/cout/ovf become valid
//   sum      : W-bit result, cout : unsigned carry, ovf : signed overflow
module rca_wide_seq
  import rca_pkg::*;
#(
  parameter int N      = RCA_DEFAULT_N,
  parameter int SLICES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N*SLICES-1:0]   a,
  input  logic [N*SLICES-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [N*SLICES-1:0]   sum,
  output logic                  cout,
  output logic                  ovf
);

  localparam int W    = N * SLICES;
  localparam int IDXW = $clog2(SLICES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SLICES - 1);

  rca_seq_state_t  state_reg;
  logic [IDXW-1:0] idx_reg;
  logic [W-1:0]    op_a_reg;
  logic [W-1:0]    op_b_reg;
  logic            carry_reg;
  // Only the lower slices are stored; the top slice goes straight into sum_reg.
  logic [W-N-1:0]  work_reg;
  logic [W-1:0]    sum_reg;
  logic            cout_reg;
  logic            ovf_reg;
  logic            busy_reg;
  logic            done_reg;

  // Operand slice selection for the shared adder.
  logic [N-1:0] a_slice [SLICES];
  logic [N-1:0] b_slice [SLICES];

  for (genvar gi = 0; gi < SLICES; gi++) begin : g_slice
    assign a_slice[gi] = op_a_reg[gi*N +: N];
    assign b_slice[gi] = op_b_reg[gi*N +: N];
  end

  logic [N-1:0] s_sum;
  logic         s_cout;

  rca_nbit #(.N(N)) u_slice (
    .A    (a_slice[idx_reg]),
    .B    (b_slice[idx_reg]),
    .cin  (carry_reg),
    .sum  (s_sum),
    .cout (s_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      op_a_reg  <= '0;
      op_b_reg  <= '0;
      carry_reg <= 1'b0;
      work_reg  <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        // DONE behaves like IDLE for acceptance, which gives back-to-back issue.
        IDLE, DONE: begin
          if (start) begin
            op_a_reg  <= a;
            op_b_reg  <= b;
            carry_reg <= cin;
            idx_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          for (int i = 0; i < SLICES - 1; i++) begin
            if (idx_reg == IDXW'(i)) work_reg[i*N +: N] <= s_sum;
          end
          carry_reg <= s_cout;
          if (idx_reg == LAST_IDX) begin
            sum_reg   <= {s_sum, work_reg};
            cout_reg  <= s_cout;
            // Signed overflow: like-signed operands giving an opposite-signed result.
            ovf_reg   <= (op_a_reg[W-1] == op_b_reg[W-1]) && (s_sum[N-1] != op_a_reg[W-1]);
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule
